// File: rtl/pipe_stage_fifo_pkg.sv
// Shared definitions for the elastic pipeline stage: default sizing, per-cycle
// operation encoding and the width helpers used to size pointers and occupancy.
package pipe_stage_fifo_pkg;

    localparam int unsigned PIPE_STAGE_DEPTH_DEFAULT  = 2;
    localparam int unsigned PIPE_STAGE_DATA_W_DEFAULT = 64;

    // What the buffer does on a given cycle; flush outranks any transfer.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_BOTH  = 3'd3,
        OP_FLUSH = 3'd4
    } fifo_op_e;

    // A DEPTH=1 buffer still carries a 1-bit pointer that never moves.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic fifo_op_e decode_op(input logic flush, input logic push, input logic pop);
        if (flush) begin
            return OP_FLUSH;
        end
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_BOTH;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: valid/ready handshake in front of a DEPTH-entry
// circular buffer, with an unconditional redirect flush.
module pipe_stage_fifo
    import pipe_stage_fifo_pkg::*;
#(
    parameter int unsigned DATA_W         = PIPE_STAGE_DATA_W_DEFAULT,
    parameter int unsigned DEPTH          = PIPE_STAGE_DEPTH_DEFAULT,
    parameter bit          REG_READY      = 1'b1,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    localparam int unsigned CNT_W         = cnt_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int unsigned      PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    fifo_op_e op;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Handshake: flush and reset both close the stage for the current cycle.
    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);

        if (reset || flush) begin
            in_ready = 1'b0;
        end else if (REG_READY) begin
            in_ready = !full;
        end else begin
            in_ready = !full || out_ready;
        end

        out_valid = !reset && !flush && !empty;
        out_data  = reset ? '0 : mem_q[rd_ptr_q];
        occupancy = reset ? '0 : count_q;

        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        op   = decode_op(flush, push, pop);
    end

    // Next state of storage, pointers and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (op)
            OP_FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                if (CLEAR_ON_FLUSH) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        mem_d[i] = '0;
                    end
                end
            end
            OP_PUSH: begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                count_d         = count_q + CNT_W'(1);
            end
            OP_POP: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_q - CNT_W'(1);
            end
            OP_BOTH: begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                rd_ptr_d        = ptr_inc(rd_ptr_q);
            end
            default: begin
            end
        endcase
    end

    // Reset always clears storage, independent of CLEAR_ON_FLUSH.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        count_q <= FULL_CNT);
    a_wr_ptr_bound: assert property (@(posedge clock) disable iff (reset)
        wr_ptr_q <= LAST_PTR);
    a_rd_ptr_bound: assert property (@(posedge clock) disable iff (reset)
        rd_ptr_q <= LAST_PTR);
    a_valid_nonempty: assert property (@(posedge clock) disable iff (reset)
        out_valid |-> (count_q != '0));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: four configurations share one stimulus stream,
// directed scenarios first, then a randomized run against a queue model.
module tb_pipe_stage_fifo;

    localparam int unsigned DW = 16;
    localparam int unsigned NI = 4;

    // Instance configurations: index -> {DEPTH, REG_READY, CLEAR_ON_FLUSH}
    int depth_c [NI] = '{2, 3, 1, 4};
    int rr_c    [NI] = '{1, 1, 0, 0};

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic [NI-1:0] d_rdy;
    logic [NI-1:0] d_vld;
    logic [DW-1:0] d_dat [NI];
    logic [2:0]    d_occ [NI];

    logic [1:0] occ0;
    logic [1:0] occ1;
    logic [0:0] occ2;
    logic [2:0] occ3;

    int nvec;
    int nerr;

    logic [DW-1:0] mq [NI][$];

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2), .REG_READY(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_d2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_rdy[0]), .in_data(in_data),
        .out_valid(d_vld[0]), .out_ready(out_ready), .out_data(d_dat[0]), .occupancy(occ0));

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3), .REG_READY(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_d3 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_rdy[1]), .in_data(in_data),
        .out_valid(d_vld[1]), .out_ready(out_ready), .out_data(d_dat[1]), .occupancy(occ1));

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(1), .REG_READY(1'b0), .CLEAR_ON_FLUSH(1'b1)) u_d1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_rdy[2]), .in_data(in_data),
        .out_valid(d_vld[2]), .out_ready(out_ready), .out_data(d_dat[2]), .occupancy(occ2));

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(4), .REG_READY(1'b0), .CLEAR_ON_FLUSH(1'b0)) u_d4 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_rdy[3]), .in_data(in_data),
        .out_valid(d_vld[3]), .out_ready(out_ready), .out_data(d_dat[3]), .occupancy(occ3));

    assign d_occ[0] = 3'(occ0);
    assign d_occ[1] = 3'(occ1);
    assign d_occ[2] = 3'(occ2);
    assign d_occ[3] = occ3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                nvec++;
                if (d_vld[i] !== 1'b0 || d_rdy[i] !== 1'b0 || d_occ[i] !== 3'd0 || d_dat[i] !== 16'h0) begin
                    nerr++;
                    $display("FAIL reset inst%0d cyc%0d: vld=%b rdy=%b occ=%0d dat=%h, want 0/0/0/0000",
                             i, c, d_vld[i], d_rdy[i], d_occ[i], d_dat[i]);
                end
            end
            @(posedge clock);
        end
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    // DEPTH=2, REG_READY=1: one transfer per cycle, one cycle of latency.
    task automatic test_streaming();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            in_valid = (k < 8);
            in_data  = 16'(k + 1);
            #1;
            nvec++;
            if (d_vld[0] !== (k >= 1 && k <= 8)) begin
                nerr++;
                $display("FAIL stream_valid cyc%0d: got %b want %b", k, d_vld[0], (k >= 1 && k <= 8));
            end
            if (k >= 1 && k <= 8) begin
                nvec++;
                if (d_dat[0] !== 16'(k)) begin
                    nerr++;
                    $display("FAIL stream_data cyc%0d: got %h want %h", k, d_dat[0], 16'(k));
                end
            end
            nvec++;
            if (d_occ[0] !== ((k >= 1 && k <= 8) ? 3'd1 : 3'd0) || (k < 8 && d_rdy[0] !== 1'b1)) begin
                nerr++;
                $display("FAIL stream_occ cyc%0d: occ=%0d rdy=%b, want occ<=1 rdy=1", k, d_occ[0], d_rdy[0]);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // DEPTH=3: fill under back-pressure, then drain through a pointer wrap.
    task automatic test_back_pressure();
        logic [DW-1:0] exp_q [$];
        int            got;
        apply_reset();
        exp_q     = '{16'hA, 16'hB, 16'hC, 16'hD};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = exp_q[k];
            #1;
            nvec++;
            if (d_rdy[1] !== 1'b1) begin
                nerr++;
                $display("FAIL bp_fill_ready push%0d: got %b want 1", k, d_rdy[1]);
            end
            tick();
        end
        in_data = 16'hD;
        for (int k = 0; k < 2; k++) begin
            #1;
            nvec++;
            if (d_occ[1] !== 3'd3 || d_rdy[1] !== 1'b0 || d_vld[1] !== 1'b1 || d_dat[1] !== 16'hA) begin
                nerr++;
                $display("FAIL bp_full hold%0d: occ=%0d rdy=%b vld=%b dat=%h, want 3/0/1/000a",
                         k, d_occ[1], d_rdy[1], d_vld[1], d_dat[1]);
            end
            tick();
        end
        out_ready = 1'b1;
        got       = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            logic accepted;
            #1;
            accepted = in_valid && d_rdy[1];
            if (d_vld[1]) begin
                nvec++;
                if (d_dat[1] !== exp_q[got]) begin
                    nerr++;
                    $display("FAIL bp_order pop%0d: got %h want %h", got, d_dat[1], exp_q[got]);
                end
                got++;
            end
            tick();
            if (accepted) in_valid = 1'b0;
        end
        nvec++;
        if (got !== 4) begin
            nerr++;
            $display("FAIL bp_drain_count: got %0d pops want 4", got);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h11;
        tick();
        in_data = 16'h22;
        tick();
        flush   = 1'b1;
        in_data = 16'h33;
        #1;
        nvec++;
        if (d_vld[0] !== 1'b0 || d_rdy[0] !== 1'b0 || d_occ[0] !== 3'd2) begin
            nerr++;
            $display("FAIL flush_cycle: vld=%b rdy=%b occ=%0d, want 0/0/2", d_vld[0], d_rdy[0], d_occ[0]);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (d_occ[i] !== 3'd0 || d_vld[i] !== 1'b0 || d_dat[i] !== 16'h0) begin
                nerr++;
                $display("FAIL flush_after inst%0d: occ=%0d vld=%b dat=%h, want 0/0/0000",
                         i, d_occ[i], d_vld[i], d_dat[i]);
            end
        end
        tick();
    endtask

    // DEPTH=1 pass-through ready: a full stage still accepts when the head leaves.
    task automatic test_pass_through();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h44;
        tick();
        out_ready = 1'b1;
        in_data   = 16'h55;
        #1;
        nvec++;
        if (d_rdy[2] !== 1'b1 || d_vld[2] !== 1'b1 || d_dat[2] !== 16'h44 || d_occ[2] !== 3'd1) begin
            nerr++;
            $display("FAIL pass_swap: rdy=%b vld=%b dat=%h occ=%0d, want 1/1/0044/1",
                     d_rdy[2], d_vld[2], d_dat[2], d_occ[2]);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        nvec++;
        if (d_occ[2] !== 3'd1 || d_vld[2] !== 1'b1 || d_dat[2] !== 16'h55) begin
            nerr++;
            $display("FAIL pass_after: occ=%0d vld=%b dat=%h, want 1/1/0055", d_occ[2], d_vld[2], d_dat[2]);
        end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < NI; i++) mq[i].delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            in_data   = 16'($urandom);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic exp_vld;
                logic exp_rdy;
                int   sz;
                sz      = mq[i].size();
                exp_vld = (sz > 0) && !flush;
                exp_rdy = !flush && ((sz < depth_c[i]) || (rr_c[i] == 0 && out_ready));
                nvec++;
                if (d_vld[i] !== exp_vld || d_rdy[i] !== exp_rdy || d_occ[i] !== 3'(sz)) begin
                    nerr++;
                    $display("FAIL rand_ctrl inst%0d cyc%0d: vld=%b rdy=%b occ=%0d, want %b/%b/%0d",
                             i, c, d_vld[i], d_rdy[i], d_occ[i], exp_vld, exp_rdy, sz);
                end
                if (exp_vld) begin
                    nvec++;
                    if (d_dat[i] !== mq[i][0]) begin
                        nerr++;
                        $display("FAIL rand_data inst%0d cyc%0d: got %h want %h", i, c, d_dat[i], mq[i][0]);
                    end
                end
                if (flush) begin
                    mq[i].delete();
                end else begin
                    if (exp_vld && out_ready) void'(mq[i].pop_front());
                    if (exp_rdy && in_valid) mq[i].push_back(in_data);
                end
            end
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_pass_through();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
